// File: rtl/exec_alu.sv
// exec_alu: execute-stage ALU with an iterative unsigned multiply/divide unit and HI/LO registers.
// Latency: combinational codes give result in the same cycle; MULTU/DIVU stall for WIDTH+1 cycles, and HI/LO update at the edge ending the last step.
// Backpressure: stall is high in the issue cycle and throughout BUSY, and drops in the retire (DONE) cycle.
// Ports: clk, reset (sync, active-high), en, alucontrol[3:0], a, b -> result, zero, stall, hi, lo.
module exec_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_div_q, is_div_d;
  // opnd holds the multiplicand (MULTU) or the divisor (DIVU).
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // acc_hi/acc_lo: partial product {upper, shifting multiplier} or {remainder, shifting quotient}.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             issue;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign issue = en && ((alucontrol == OP_MULTU) || (alucontrol == OP_DIVU));

  // One iteration of either algorithm, computed from the private registers.
  always_comb begin
    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // the whole {carry, upper, lower} right by one.
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. Divisor 0 always fits, giving all-ones
    // quotient and the dividend as remainder.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          stall    = 1'b1;
          state_d  = S_BUSY;
          count_d  = '0;
          is_div_d = (alucontrol == OP_DIVU);
          opnd_d   = (alucontrol == OP_DIVU) ? b : a;
          acc_hi_d = '0;
          acc_lo_d = (alucontrol == OP_DIVU) ? a : b;
        end
      end
      S_BUSY: begin
        stall    = 1'b1;
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          hi_d    = step_hi;
          lo_d    = step_lo;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // en is deliberately ignored here so a held MULTU/DIVU does not reissue.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    result = '0;
    case (alucontrol)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SRL:  result = b >> a[4:0];
      OP_MFHI: result = hi_q;
      OP_MFLO: result = lo_q;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: directed bench for exec_alu with a cycle-level reference model.
// Latency: model mirrors the architectural timing (WIDTH+1 stall cycles, HI/LO written at the end).
// Backpressure: stall compared every cycle against the model.
module tb_exec_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [3:0]   alucontrol;
  logic [W-1:0] a, b;
  logic [W-1:0] result, hi, lo;
  logic         zero, stall;

  exec_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .alucontrol(alucontrol),
    .a(a), .b(b), .result(result), .zero(zero), .stall(stall),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           busy_left = 0;   // BUSY cycles still to run
  bit           retiring = 1'b0; // the cycle after the result is written

  function automatic bit is_iter(input logic [3:0] op);
    return (op == 4'b1100) || (op == 4'b1101);
  endfunction

  function automatic logic [W-1:0] exp_result(input logic [3:0] op, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b1010: return x - y;
      4'b1011: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b0100: return y >> x[4:0];
      4'b1110: return m_hi;
      4'b1111: return m_lo;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [2*W-1:0] prod;
    if (reset) begin
      busy_left = 0; retiring = 1'b0; m_hi = '0; m_lo = '0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; retiring = 1'b1;
      end
    end else if (retiring) begin
      retiring = 1'b0;
    end else if (en && is_iter(alucontrol)) begin
      if (alucontrol == 4'b1100) begin
        prod = {32'b0, a} * {32'b0, b};
        p_hi = prod[2*W-1:W]; p_lo = prod[W-1:0];
      end else if (b == 0) begin
        p_hi = a; p_lo = '1;
      end else begin
        p_hi = a % b; p_lo = a / b;
      end
      busy_left = W;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] er;
    if (chk_en) begin
      er = exp_result(alucontrol, a, b);
      check("cyc_result", result, er);
      check("cyc_zero", {31'b0, zero}, {31'b0, (er == 0)});
      check("cyc_stall", {31'b0, stall},
            {31'b0, (busy_left > 0) || (!retiring && en && is_iter(alucontrol))});
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic e, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    en = e; alucontrol = op; a = x; b = y;
  endtask

  task automatic comb(input string name, input logic [3:0] op, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] exp);
    drive(1'b1, op, x, y);
    @(negedge clk);
    check(name, result, exp);
    check({name, "_zero"}, {31'b0, zero}, {31'b0, (exp == 0)});
  endtask

  // Counts stalled cycles from the next negedge until stall drops (bounded).
  // With toggle set, en/a/b are scrambled while BUSY; op stays iterative.
  task automatic wait_done(output int cnt, input bit toggle);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) return;
      cnt++;
      if (toggle && cnt > 1 && cnt < 30) begin
        #1;
        en = $urandom_range(0, 1);
        a  = $urandom;
        b  = $urandom;
      end
    end
    check("timeout_stall", 32'd1, 32'd0);
  endtask

  int cnt;

  initial begin
    reset = 1'b1; en = 1'b0; alucontrol = 4'b0000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);

    // Combinational sweep
    comb("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1,        32'h80000000);
    comb("sub_eq",  4'b1010, 32'd5,        32'd5,        32'h0);
    comb("slt_neg", 4'b1011, 32'hFFFFFFFF, 32'h1,        32'h1);
    comb("slt_pos", 4'b1011, 32'h1,        32'hFFFFFFFF, 32'h0);
    comb("srl",     4'b0100, 32'd4,        32'h80000000, 32'h08000000);
    comb("and",     4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    comb("or",      4'b0001, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0);
    comb("undef",   4'b0111, 32'h12345678, 32'h1,        32'h0);

    // MULTU max x max
    drive(1'b1, 4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cnt, 1'b0);
    check("mul_stalls", cnt, 32'd33);
    check("mul_hi", hi, 32'hFFFFFFFE);
    check("mul_lo", lo, 32'h00000001);
    comb("mfhi", 4'b1110, 32'h0, 32'h0, 32'hFFFFFFFE);
    comb("mflo", 4'b1111, 32'h0, 32'h0, 32'h00000001);

    // DIVU 100 / 7
    drive(1'b1, 4'b1101, 32'd100, 32'd7);
    wait_done(cnt, 1'b0);
    check("div_stalls", cnt, 32'd33);
    check("div_lo", lo, 32'd14);
    check("div_hi", hi, 32'd2);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);

    // MULTU with operands/en scrambled during BUSY
    drive(1'b1, 4'b1100, 32'd3, 32'd5);
    wait_done(cnt, 1'b1);
    check("tog_stalls", cnt, 32'd33);
    check("tog_hi", hi, 32'd0);
    check("tog_lo", lo, 32'd15);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);

    // MULTU held on en through DONE issues once; next begins right after DONE
    drive(1'b1, 4'b1100, 32'd6, 32'd7);
    wait_done(cnt, 1'b0);
    check("hold_stalls", cnt, 32'd33);
    check("hold_lo", lo, 32'd42);
    #1 a = 32'd2; b = 32'd9;   // en stays high: reissue in the next (IDLE) cycle
    wait_done(cnt, 1'b0);
    check("reissue_stalls", cnt, 32'd33);
    check("reissue_lo", lo, 32'd18);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);

    // DIVU by zero
    drive(1'b1, 4'b1101, 32'h1234ABCD, 32'h0);
    wait_done(cnt, 1'b0);
    check("div0_lo", lo, 32'hFFFFFFFF);
    check("div0_hi", hi, 32'h1234ABCD);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);

    // Reset during BUSY cycle 10
    drive(1'b1, 4'b1100, 32'hFFFFFFFF, 32'd2);
    @(negedge clk); #1 en = 1'b0;               // T0
    repeat (10) @(negedge clk);                  // T1..T10
    #1 reset = 1'b1;
    @(negedge clk);
    check("rstb_stall", {31'b0, stall}, 32'h0);
    check("rstb_hi", hi, 32'h0);
    check("rstb_lo", lo, 32'h0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstb_idle_stall", {31'b0, stall}, 32'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_alu.md
# exec_alu

Execute-stage ALU for the single-cycle MIPS datapath. It consumes the 4-bit `alucontrol` code from the ALU decoder and the two operands, and produces `result` and `zero`. It also contains an iterative unsigned multiply/divide unit with HI/LO registers. While that unit runs, it raises `stall` to freeze the PC and register-file writes, and drops `stall` in the cycle the instruction retires.

## Interface
- `WIDTH`, default 32: operand/result width; the iteration count equals `WIDTH`.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `en`  in  1  execute-stage instruction valid
- `alucontrol`  in  4  operation code from the ALU decoder
- `a`  in  WIDTH  operand A (rs)
- `b`  in  WIDTH  operand B (rt or immediate)
- `result`  out  WIDTH  ALU result
- `zero`  out  1  `result == 0`
- `stall`  out  1  hold the PC and suppress all architectural writes this cycle
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- Combinational codes (`result` valid in the same cycle, no state change):
  - `0000` AND: `a & b`
  - `0001` OR: `a | b`
  - `0010` ADD: `a + b`, modulo 2^WIDTH, no overflow trap
  - `1010` SUB: `a - b`, modulo 2^WIDTH
  - `1011` SLT: 1 if `a < b` (signed) else 0, zero-extended
  - `0100` SRL: `b >> a[4:0]`, logical
  - `1110` MFHI: `result = hi`
  - `1111` MFLO: `result = lo`
  - Any other combinational code: `result = 0`
- Iterative codes:
  - `1100` MULTU: `{hi,lo} = a * b`, unsigned, 2·WIDTH bits
  - `1101` DIVU: `lo = a / b`, `hi = a % b`, unsigned, restoring division
- Divide by zero is not trapped. It produces `lo = all ones` and `hi = a`, the natural restoring result.
- FSM states:
  - IDLE
    - If `en` and the code is MULTU or DIVU: latch `a`, `b` and the op; clear `count`; go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY
    - One shift-add (MULTU) or shift-subtract (DIVU) step per cycle; `count` increments.
    - When `count == WIDTH-1`, this cycle's step is the last. Write final `hi`/`lo` at the clock edge and go to DONE.
  - DONE
    - One cycle, then IDLE.
    - `en` is not re-sampled, so the still-present MULTU/DIVU instruction does not reissue.
- `stall` is combinational:
  - 1 when in IDLE with `en` and an iterative code.
  - 1 in BUSY.
  - 0 otherwise.
- `result` during MULTU/DIVU is 0.
- `hi`/`lo` change only at the completion edge. Intermediate partial products and remainders live in private registers.
- `en` and operand changes during BUSY are ignored.

## Timing
- Reset values:
  - state = IDLE, `count` = 0, `hi` = 0, `lo` = 0, private datapath registers = 0.
  - Outputs after reset: `stall` = 0 unless IDLE issue conditions hold; `result` and `zero` follow the combinational inputs.
- Issue cycle is T0: `stall` = 1.
- BUSY spans T1..T_WIDTH with `stall` = 1. The edge ending T_WIDTH writes `hi`/`lo`.
- T_WIDTH+1 is DONE:
  - `stall` = 0 and the instruction retires.
  - MFHI/MFLO issued in the next cycle see the new values.
- Total stall cycles: WIDTH+1 (33 for WIDTH = 32).
- `reset` asserted mid-BUSY: at the next edge go to IDLE and clear `hi`/`lo`; the partial result is discarded. `stall` stays 0 afterwards unless a new issue condition is present.
- Back-to-back MULTU after DONE: the new instruction issues in the cycle after DONE (IDLE).

## Test plan
- Combinational sweep:
  - ADD `7FFFFFFF + 1` → `result = 80000000`, `zero` = 0.
  - SUB `5 - 5` → `result = 0`, `zero` = 1.
  - SLT `FFFFFFFF, 1` → `result = 1`.
  - SRL `b = 80000000`, `a = 4` → `result = 08000000`.
- MULTU `FFFFFFFF × FFFFFFFF`:
  - `stall` high for exactly 33 cycles.
  - Then `hi = FFFFFFFE`, `lo = 00000001`.
  - MFHI in the following cycle returns `FFFFFFFE`.
- DIVU `100 / 7` → `lo = 14`, `hi = 2` (decimal); latency 33 stall cycles.
- DIVU by zero with `a = 1234ABCD` → `lo = FFFFFFFF`, `hi = 1234ABCD`.
- `reset` pulse at BUSY cycle 10 of a MULTU:
  - Next cycle: IDLE, `hi = lo = 0`, `stall` = 0 (with `en` = 0).
- Operand and `en` toggled during BUSY: final `hi`/`lo` match the operands latched at issue. A MULTU held on `en` through DONE issues once only, and the next MULTU begins the cycle after DONE.
